// File: rtl/xor_gate_sync_if.sv
// rtl/xor_gate_sync_if.sv - operand/result bundle for the registered XOR compare stage
interface xor_gate_sync_if #(
  parameter int WIDTH = 1,
  parameter int ACC_W = 16
);
  localparam int HD_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             in_valid;
  logic             acc_clr;
  logic [WIDTH-1:0] out1;
  logic             out_valid;
  logic             out_parity;
  logic [HD_W-1:0]  out_hdist;
  logic [ACC_W-1:0] acc_total;
  logic             acc_sat;

  // master supplies operands and observes results; slave is the compare stage
  modport master (
    output in1, in2, in_valid, acc_clr,
    input  out1, out_valid, out_parity, out_hdist, acc_total, acc_sat
  );

  modport slave (
    input  in1, in2, in_valid, acc_clr,
    output out1, out_valid, out_parity, out_hdist, acc_total, acc_sat
  );
endinterface

// File: rtl/xor_gate_sync.sv
// rtl/xor_gate_sync.sv - registered bitwise XOR with parity; XOR_GATE_STATS_EN adds Hamming distance and saturating accumulator
module xor_gate_sync #(
  parameter int WIDTH = 1,
  parameter int ACC_W = 16
) (
  input  logic           clk,
  input  logic           rst,
  xor_gate_sync_if.slave bus
);
  localparam int HD_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] r_out1;
  logic             r_valid;
  logic             r_parity;

  assign w_diff = bus.in1 ^ bus.in2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out1   <= '0;
      r_valid  <= 1'b0;
      r_parity <= 1'b0;
    end else begin
      r_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_out1   <= w_diff;
        r_parity <= ^w_diff;
      end
    end
  end

  assign bus.out1       = r_out1;
  assign bus.out_valid  = r_valid;
  assign bus.out_parity = r_parity;

`ifdef XOR_GATE_STATS_EN
  // sum is wide enough for both operands plus carry, so saturation never misses a wrap
  localparam int SUM_W = ((ACC_W > HD_W) ? ACC_W : HD_W) + 1;

  logic [HD_W-1:0]  w_pop;
  logic [ACC_W-1:0] w_acc_base;
  logic [SUM_W-1:0] w_sum;
  logic [ACC_W-1:0] w_acc_load;
  logic [HD_W-1:0]  r_hdist;
  logic [ACC_W-1:0] r_acc;
  logic             r_sat;

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_pop = w_pop + HD_W'(w_diff[i]);
    end
  end

  // a same-cycle clear loads the new sample on top of zero
  always_comb begin
    w_acc_base = bus.acc_clr ? '0 : r_acc;
    w_sum      = SUM_W'(w_acc_base) + SUM_W'(w_pop);
    w_acc_load = (|w_sum[SUM_W-1:ACC_W]) ? '1 : w_sum[ACC_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hdist <= '0;
      r_acc   <= '0;
      r_sat   <= 1'b0;
    end else if (bus.in_valid) begin
      r_hdist <= w_pop;
      r_acc   <= w_acc_load;
      r_sat   <= &w_acc_load;
    end else if (bus.acc_clr) begin
      r_acc <= '0;
      r_sat <= 1'b0;
    end
  end

  assign bus.out_hdist = r_hdist;
  assign bus.acc_total = r_acc;
  assign bus.acc_sat   = r_sat;
`else
  logic w_unused_acc_clr;

  assign w_unused_acc_clr = bus.acc_clr;
  assign bus.out_hdist    = '0;
  assign bus.acc_total    = '0;
  assign bus.acc_sat      = 1'b0;
`endif

endmodule

// File: tb/tb_xor_gate_sync.sv
// tb/tb_xor_gate_sync.sv - directed bench for xor_gate_sync in 1-bit and 8-bit configurations
module tb_xor_gate_sync;
`ifdef XOR_GATE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  xor_gate_sync_if #(.WIDTH(1), .ACC_W(16)) ia ();
  xor_gate_sync_if #(.WIDTH(8), .ACC_W(16)) ib ();
  xor_gate_sync_if #(.WIDTH(8), .ACC_W(4))  ic ();

  xor_gate_sync #(.WIDTH(1), .ACC_W(16)) u_a (.clk(clk), .rst(rst), .bus(ia.slave));
  xor_gate_sync #(.WIDTH(8), .ACC_W(16)) u_b (.clk(clk), .rst(rst), .bus(ib.slave));
  xor_gate_sync #(.WIDTH(8), .ACC_W(4))  u_c (.clk(clk), .rst(rst), .bus(ic.slave));

  typedef struct packed {
    logic       rst;
    logic       v;
    logic       a;
    logic       b;
    logic       e_out;
    logic       e_valid;
    logic       e_par;
    logic [3:0] e_acc;
  } vec_t;

  vec_t tbl [13];

  function automatic logic [63:0] st(input logic [63:0] v);
    return STATS ? v : 64'd0;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // rst, v, in1, in2, out1, out_valid, out_parity, acc_total (stats build)
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'd1};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'd2};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd2};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'd1};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'd1};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'd1};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd1};
    tbl[11] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'd1};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1};

    ia.in1 = '0; ia.in2 = '0; ia.in_valid = 1'b0; ia.acc_clr = 1'b0;
    ib.in1 = '0; ib.in2 = '0; ib.in_valid = 1'b0; ib.acc_clr = 1'b0;
    ic.in1 = '0; ic.in2 = '0; ic.in_valid = 1'b0; ic.acc_clr = 1'b0;

    // 1-bit gate: reset, truth table, mid-stream reset, hold
    for (int i = 0; i < 13; i++) begin
      rst         = tbl[i].rst;
      ia.in_valid = tbl[i].v;
      ia.in1      = tbl[i].a;
      ia.in2      = tbl[i].b;
      tick();
      check($sformatf("a_out1[%0d]", i), 64'(ia.out1), 64'(tbl[i].e_out));
      check($sformatf("a_valid[%0d]", i), 64'(ia.out_valid), 64'(tbl[i].e_valid));
      check($sformatf("a_parity[%0d]", i), 64'(ia.out_parity), 64'(tbl[i].e_par));
      check($sformatf("a_hdist[%0d]", i), 64'(ia.out_hdist), st(64'(tbl[i].e_out)));
      check($sformatf("a_acc[%0d]", i), 64'(ia.acc_total), st(64'(tbl[i].e_acc)));
    end
    rst = 1'b0;
    ia.in_valid = 1'b0;

    // 8-bit Hamming/parity and accumulate, then clear collisions
    ib.in1 = 8'hF0; ib.in2 = 8'h0F; ib.in_valid = 1'b1;
    tick();
    check("b_out1_ff", 64'(ib.out1), 64'hFF);
    check("b_hdist_8", 64'(ib.out_hdist), st(64'd8));
    check("b_parity_0", 64'(ib.out_parity), 64'd0);
    check("b_acc_8", 64'(ib.acc_total), st(64'd8));
    ib.in1 = 8'h01; ib.in2 = 8'h00;
    tick();
    check("b_hdist_1", 64'(ib.out_hdist), st(64'd1));
    check("b_parity_1", 64'(ib.out_parity), 64'd1);
    check("b_acc_9", 64'(ib.acc_total), st(64'd9));
    ib.in1 = 8'h03; ib.acc_clr = 1'b1;
    tick();
    check("b_clr_load_acc", 64'(ib.acc_total), st(64'd2));
    check("b_clr_load_out1", 64'(ib.out1), 64'h03);
    check("b_clr_load_parity", 64'(ib.out_parity), 64'd0);
    ib.in_valid = 1'b0; ib.in1 = 8'hAA;
    tick();
    check("b_clr_only_acc", 64'(ib.acc_total), 64'd0);
    check("b_clr_only_out1", 64'(ib.out1), 64'h03);
    check("b_clr_only_valid", 64'(ib.out_valid), 64'd0);
    check("b_clr_only_hdist", 64'(ib.out_hdist), st(64'd2));
    ib.acc_clr = 1'b0;

    // 4-bit accumulator saturation, sticky flag, clear-then-load, reset
    ic.in1 = 8'hFF; ic.in2 = 8'h00; ic.in_valid = 1'b1;
    tick();
    check("c_acc_8", 64'(ic.acc_total), st(64'd8));
    check("c_sat_0", 64'(ic.acc_sat), 64'd0);
    tick();
    check("c_acc_15", 64'(ic.acc_total), st(64'd15));
    check("c_sat_1", 64'(ic.acc_sat), st(64'd1));
    tick();
    check("c_acc_hold_15", 64'(ic.acc_total), st(64'd15));
    check("c_sat_sticky", 64'(ic.acc_sat), st(64'd1));
    ic.in1 = 8'h03; ic.acc_clr = 1'b1;
    tick();
    check("c_clr_load_acc", 64'(ic.acc_total), st(64'd2));
    check("c_clr_load_sat", 64'(ic.acc_sat), 64'd0);
    ic.acc_clr = 1'b0; ic.in1 = 8'hFF;
    tick();
    check("c_acc_10", 64'(ic.acc_total), st(64'd10));
    rst = 1'b1; ic.in1 = 8'h0F;
    tick();
    check("c_rst_out1", 64'(ic.out1), 64'd0);
    check("c_rst_valid", 64'(ic.out_valid), 64'd0);
    check("c_rst_hdist", 64'(ic.out_hdist), 64'd0);
    check("c_rst_acc", 64'(ic.acc_total), 64'd0);
    check("c_rst_sat", 64'(ic.acc_sat), 64'd0);
    rst = 1'b0;
    tick();
    check("c_after_rst_out1", 64'(ic.out1), 64'h0F);
    check("c_after_rst_acc", 64'(ic.acc_total), st(64'd4));
    ic.in_valid = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
